// File: rtl/pcileech_tlp_pkg.sv
// Shared TLP constants, MSI source state encoding and beat container.
package pcileech_tlp_pkg;

  localparam logic [7:0] TLP_FMTTYPE_MWR32 = 8'h40;
  localparam logic [7:0] TLP_FMTTYPE_MWR64 = 8'h60;
  localparam logic [3:0] TLP_BE_FIRST_ALL  = 4'hF;
  localparam logic [9:0] TLP_LEN_1DW       = 10'd1;

  typedef enum logic [1:0] {IDLE, ARMED, BEAT1, HOLD} msi_state_t;

  typedef struct packed {
    logic [127:0] data;
    logic [3:0]   keepdw;
  } tlp_beat_t;

  // Header DW0 for a single-DW memory write: {fmt/type, reserved, length}.
  function automatic logic [31:0] mwr_dw0(input logic [7:0] fmttype);
    return {fmttype, 14'h0, TLP_LEN_1DW};
  endfunction

endpackage

// File: rtl/pcileech_tlp_if.sv
// 128-bit TLP AXI-stream bundle; has_data lets the TX mux arbitrate ahead of tvalid.
interface IfAXIS128;
  logic [127:0] tdata;
  logic [3:0]   tkeepdw;
  logic         tlast;
  logic [8:0]   tuser;
  logic         tvalid;
  logic         has_data;
  logic         tready;

  modport source(output tdata, tkeepdw, tlast, tuser, tvalid, has_data, input tready);
  modport sink(input tdata, tkeepdw, tlast, tuser, tvalid, has_data, output tready);
endinterface

// File: rtl/pcileech_tlp_mwr_hdr_build.sv
// Combinational builder for the beats of a 1-DW MSI memory write (3DW or 4DW header).
module pcileech_tlp_mwr_hdr_build
  import pcileech_tlp_pkg::*;
(
  input  logic        kind64,
  input  logic [15:0] pcie_id,
  input  logic [7:0]  tag,
  input  logic [63:2] addr,
  input  logic [31:0] data,
  output tlp_beat_t   beat0,
  output tlp_beat_t   beat1
);

  logic [31:0] dw1;
  logic [31:0] addr_lo;

  assign dw1     = {pcie_id, tag, 4'h0, TLP_BE_FIRST_ALL};
  assign addr_lo = {addr[31:2], 2'b00};

  always_comb begin
    beat0.keepdw = 4'hF;
    beat1.keepdw = 4'h1;
    beat1.data   = {96'h0, data};
    // 4DW header pushes the payload DW into a second beat.
    if (kind64)
      beat0.data = {addr_lo, addr[63:32], dw1, mwr_dw0(TLP_FMTTYPE_MWR64)};
    else
      beat0.data = {data, addr_lo, dw1, mwr_dw0(TLP_FMTTYPE_MWR32)};
  end

endmodule

// File: rtl/pcileech_tlps128_msi_source.sv
// MSI MWr TLP source: counts interrupt requests and emits one TLP per request,
// honouring the TX mux's one-cycle tready-to-beat latency and a post-TLP holdoff.
module pcileech_tlps128_msi_source
  import pcileech_tlp_pkg::*;
#(
  parameter int MAX_PENDING    = 15,
  parameter int HOLDOFF_CYCLES = 16
) (
  input  logic           clk_pcie,
  input  logic           rst,
  input  logic           irq_req,
  input  logic           int_enable,
  input  logic [63:0]    i_addr,
  input  logic [31:0]    i_data,
  input  logic [15:0]    pcie_id,
  IfAXIS128.source       tlps_out,
  output logic [3:0]     pending,
  output logic [15:0]    drop_cnt
);

  localparam int HW = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;
  localparam logic [3:0] PEND_MAX = 4'(MAX_PENDING);
  localparam msi_state_t POST_TLP = (HOLDOFF_CYCLES == 0) ? IDLE : HOLD;

  msi_state_t    state, state_nxt;
  logic [63:2]   addr_q;
  logic [31:0]   data_q;
  logic          kind64_q;
  logic [7:0]    tag;
  logic [HW-1:0] hold_cnt;
  logic          accept, load0, load1, load_last, inc, clr_pend;
  tlp_beat_t     beat0, beat1;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^i_addr[1:0];

  pcileech_tlp_mwr_hdr_build u_hdr (
    .kind64  (kind64_q),
    .pcie_id (pcie_id),
    .tag     (tag),
    .addr    (addr_q),
    .data    (data_q),
    .beat0   (beat0),
    .beat1   (beat1)
  );

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    load0     = 1'b0;
    load1     = 1'b0;
    case (state)
      IDLE: if (int_enable && pending != 4'd0) begin
        accept    = 1'b1;
        state_nxt = ARMED;
      end
      ARMED: if (tlps_out.tready) begin
        load0     = 1'b1;
        state_nxt = kind64_q ? BEAT1 : POST_TLP;
      end
      BEAT1: if (tlps_out.tready) begin
        load1     = 1'b1;
        state_nxt = POST_TLP;
      end
      HOLD: if (hold_cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign load_last = (load0 && !kind64_q) || load1;
  assign inc       = irq_req && int_enable;
  assign clr_pend  = !int_enable && (state == IDLE || state == HOLD);

  // has_data drops as soon as the tlast beat is loaded so the mux releases us.
  assign tlps_out.has_data = (state == ARMED) || (state == BEAT1);

  always_ff @(posedge clk_pcie) begin
    if (rst) begin
      state    <= IDLE;
      hold_cnt <= '0;
      tag      <= 8'h00;
      addr_q   <= '0;
      data_q   <= '0;
      kind64_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt == HOLD && state != HOLD)
        hold_cnt <= HW'(HOLDOFF_CYCLES);
      else if (state == HOLD && hold_cnt != '0)
        hold_cnt <= hold_cnt - 1'b1;
      if (load_last) tag <= tag + 8'd1;
      if (accept) begin
        addr_q   <= i_addr[63:2];
        data_q   <= i_data;
        kind64_q <= |i_addr[63:32];
      end
    end
  end

  // A request that coincides with a completed TLP nets to no change.
  always_ff @(posedge clk_pcie) begin
    if (rst) begin
      pending  <= 4'd0;
      drop_cnt <= 16'h0;
    end else if (clr_pend) begin
      pending <= 4'd0;
    end else begin
      case ({inc, load_last})
        2'b10: begin
          if (pending >= PEND_MAX) begin
            if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
          end else begin
            pending <= pending + 4'd1;
          end
        end
        2'b01:   pending <= pending - 4'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_pcie) begin
    if (rst) begin
      tlps_out.tvalid  <= 1'b0;
      tlps_out.tlast   <= 1'b0;
      tlps_out.tkeepdw <= 4'h0;
      tlps_out.tdata   <= '0;
      tlps_out.tuser   <= 9'h000;
    end else begin
      tlps_out.tvalid <= load0 || load1;
      if (load0) begin
        tlps_out.tdata   <= beat0.data;
        tlps_out.tkeepdw <= beat0.keepdw;
        tlps_out.tlast   <= !kind64_q;
        tlps_out.tuser   <= 9'h001;
      end else if (load1) begin
        tlps_out.tdata   <= beat1.data;
        tlps_out.tkeepdw <= beat1.keepdw;
        tlps_out.tlast   <= 1'b1;
        tlps_out.tuser   <= 9'h000;
      end
    end
  end

endmodule
